// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the pipelined core.
//   - icode constants (HALT..POPQ)
//   - one-hot status codes STAT_AOK/HLT/ADR/INS, bit order [0:3]
//   - RNONE register id
//   - D-register record type and its bubble value (also used by decode's E bubble)
//   - instruction length / field-presence helpers
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [0:3] STAT_HLT = 4'b0100;
  localparam logic [0:3] STAT_ADR = 4'b0010;
  localparam logic [0:3] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [0:3]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam logic [0:3]  BUBBLE_STAT  = STAT_AOK;
  localparam logic [3:0]  BUBBLE_ICODE = I_NOP;
  localparam logic [3:0]  BUBBLE_IFUN  = 4'h0;
  localparam logic [63:0] BUBBLE_VAL   = 64'd0;

  localparam d_reg_t D_BUBBLE = '{
    stat:  BUBBLE_STAT,
    icode: BUBBLE_ICODE,
    ifun:  BUBBLE_IFUN,
    ra:    RNONE,
    rb:    RNONE,
    valc:  BUBBLE_VAL,
    valp:  BUBBLE_VAL
  };

  // Encoded length in bytes; undefined icodes count as one byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
      I_JXX, I_CALL:                    instr_len = 4'd9;
      default:                          instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_regids(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: has_regids = 1'b1;
      default:                has_regids = 1'b0;
    endcase
  endfunction

  function automatic logic has_valc(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: has_valc = 1'b1;
      default:                                     has_valc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Combinational pipeline hazard control.
//   Inputs : D_icode, E_icode, M_icode  icodes in D/E/M
//            E_dstM                     load destination in E
//            d_srcA, d_srcB             decode source registers
//            e_Cnd                      branch condition from execute
//   Outputs: F_stall, D_stall, D_bubble, E_bubble
module pipe_ctrl
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble
);

  logic load_use;
  logic ret_pend;
  logic mispred;

  assign load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
                    (E_dstM != RNONE) &&
                    (E_dstM == d_srcA || E_dstM == d_srcB);
  assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispred  = (E_icode == I_JXX) && !e_Cnd;

  assign F_stall  = load_use | ret_pend;
  assign D_stall  = load_use;
  // A load-use stall keeps the instruction in D, so it must not be bubbled.
  assign D_bubble = mispred | (ret_pend & !load_use);
  assign E_bubble = mispred | load_use;

endmodule

// File: rtl/fetch.sv
// Y86-64 fetch stage with F/D pipeline registers and hazard control.
//   clk, rst                         clock, synchronous active-high reset
//   imem_we/imem_addr/imem_wdata     byte load port into instruction memory
//   M_icode, M_Cnd, M_valA           mispredicted jXX recovery from M
//   W_icode, W_valM                  ret return address from W
//   E_icode, E_dstM, e_Cnd           execute-stage hazard sources
//   d_srcA, d_srcB                   decode source registers
//   D_stat..D_valP                   D pipeline register outputs
//   E_bubble                         combinational bubble request for E
//   F_predPC                         predicted PC register
module fetch
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_we,
  input  logic [63:0] imem_addr,
  input  logic [7:0]  imem_wdata,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  W_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [63:0] W_valM,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [0:3]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        E_bubble,
  output logic [63:0] F_predPC
);

  localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] MEM_END = 65'(IMEM_BYTES);

  logic [7:0] imem [IMEM_BYTES];

  // Writes are independent of rst so a program can be loaded while held in reset.
  always_ff @(posedge clk) begin
    if (imem_we && ({1'b0, imem_addr} < MEM_END)) begin
      imem[imem_addr[AW-1:0]] <= imem_wdata;
    end
  end

  // PC select: M-stage mispredict recovery beats W-stage ret.
  logic [63:0] f_pc;
  always_comb begin
    f_pc = F_predPC;
    if (M_icode == I_JXX && !M_Cnd) f_pc = M_valA;
    else if (W_icode == I_RET)      f_pc = W_valM;
  end

  // Ten instruction bytes; bytes beyond the memory read as zero. Any
  // instruction touching them is flagged ADR and its fields are discarded.
  logic [7:0] fb [10];
  for (genvar k = 0; k < 10; k++) begin : g_byte
    logic [63:0] a;
    assign a     = f_pc + 64'(k);
    assign fb[k] = ({1'b0, a} < MEM_END) ? imem[a[AW-1:0]] : 8'h00;
  end

  logic [3:0]  raw_icode;
  logic [3:0]  raw_ifun;
  logic [3:0]  len;
  logic        adr;
  logic [63:0] valc_raw;

  assign raw_icode = fb[0][7:4];
  assign raw_ifun  = fb[0][3:0];
  assign len       = instr_len(raw_icode);
  // 65-bit sum so a PC near 2^64 cannot wrap back into range.
  assign adr       = ({1'b0, f_pc} + 65'(len)) > MEM_END;
  // valC follows the register byte when one is present.
  assign valc_raw  = has_regids(raw_icode) ?
                     {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]} :
                     {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};

  d_reg_t      f_d;
  logic [63:0] f_pred;

  always_comb begin
    f_d.stat  = STAT_AOK;
    f_d.icode = raw_icode;
    f_d.ifun  = raw_ifun;
    f_d.ra    = RNONE;
    f_d.rb    = RNONE;
    f_d.valc  = 64'd0;
    f_d.valp  = f_pc + 64'(len);
    if (adr) begin
      f_d.stat  = STAT_ADR;
      f_d.icode = I_NOP;
      f_d.ifun  = 4'h0;
    end else begin
      if (has_regids(raw_icode)) begin
        f_d.ra = fb[1][7:4];
        f_d.rb = fb[1][3:0];
      end
      if (has_valc(raw_icode)) f_d.valc = valc_raw;
      if (raw_icode > I_POPQ)       f_d.stat = STAT_INS;
      else if (raw_icode == I_HALT) f_d.stat = STAT_HLT;
    end
  end

  assign f_pred = (f_d.icode == I_JXX || f_d.icode == I_CALL) ? f_d.valc : f_d.valp;

  d_reg_t d_q;
  logic   f_stall;
  logic   d_stall;
  logic   d_bubble;

  pipe_ctrl u_pipe_ctrl (
    .D_icode  (d_q.icode),
    .E_icode  (E_icode),
    .M_icode  (M_icode),
    .E_dstM   (E_dstM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .e_Cnd    (e_Cnd),
    .F_stall  (f_stall),
    .D_stall  (d_stall),
    .D_bubble (d_bubble),
    .E_bubble (E_bubble)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      F_predPC <= 64'd0;
      d_q      <= D_BUBBLE;
    end else begin
      if (!f_stall) F_predPC <= f_pred;
      if (!d_stall) d_q <= d_bubble ? D_BUBBLE : f_d;
    end
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: behavioural model + scoreboard queue + monitor.
module tb_fetch;

  localparam int IMEM = 1024;
  localparam int W    = 213;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [7:0]  imem_wdata;
  logic [3:0]  M_icode, W_icode, E_icode, E_dstM, d_srcA, d_srcB;
  logic        M_Cnd, e_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [0:3]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP, F_predPC;
  logic        E_bubble;

  fetch #(.IMEM_BYTES(IMEM)) dut (
    .clk(clk), .rst(rst),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .M_icode(M_icode), .W_icode(W_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_valM(W_valM), .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble), .F_predPC(F_predPC)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [IMEM];
  logic [7:0]  prog  [IMEM];
  int unsigned len_tab [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
  logic [3:0]  m_stat, m_icode, m_ifun, m_ra, m_rb;
  logic [63:0] m_valc, m_valp, m_pred;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'(IMEM)) ? mem_m[a[9:0]] : 8'h00;
  endfunction

  function automatic int unsigned len_of(input logic [3:0] ic);
    return (ic <= 4'd11) ? len_tab[int'(ic)] : 1;
  endfunction

  // Fields follow the length: 2/10-byte forms carry a register byte,
  // 9/10-byte forms end with an 8-byte little-endian constant.
  task automatic model_fetch(input logic [63:0] pc,
                             output logic [3:0] st, output logic [3:0] ic,
                             output logic [3:0] fn, output logic [3:0] ra,
                             output logic [3:0] rb, output logic [63:0] vc,
                             output logic [63:0] vp, output logic [63:0] pr);
    logic [7:0] b0, b1;
    logic [3:0] raw;
    int unsigned len;
    b0  = rd(pc);
    raw = b0[7:4];
    fn  = b0[3:0];
    ic  = raw;
    len = len_of(raw);
    ra  = 4'hF;
    rb  = 4'hF;
    vc  = 64'd0;
    vp  = pc + 64'(len);
    if (pc > 64'(IMEM - len)) begin
      st = 4'b0010;
      ic = 4'h1;
      fn = 4'h0;
    end else begin
      if (len == 2 || len == 10) begin
        b1 = rd(pc + 64'd1);
        ra = b1[7:4];
        rb = b1[3:0];
      end
      if (len >= 9)
        for (int i = 0; i < 8; i++) vc = vc | (64'(rd(pc + 64'(len - 8 + i))) << (8 * i));
      st = (raw > 4'd11) ? 4'b0001 : (raw == 4'd0) ? 4'b0100 : 4'b1000;
    end
    pr = (ic == 4'd7 || ic == 4'd8) ? vc : vp;
  endtask

  task automatic set_bubble();
    m_stat = 4'b1000; m_icode = 4'h1; m_ifun = 4'h0;
    m_ra = 4'hF; m_rb = 4'hF; m_valc = 64'd0; m_valp = 64'd0;
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge with inputs set; predicts the state
  // after the coming rising edge, queues it, then waits for the next fall.
  task automatic step();
    logic lu, rp, mp, eb;
    logic [63:0] pc, vc, vp, pr;
    logic [3:0] st, ic, fn, ra, rb;
    lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = (m_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mp = (E_icode == 4'd7) && !e_Cnd;
    eb = mp | lu;
    if (M_icode == 4'd7 && !M_Cnd) pc = M_valA;
    else if (W_icode == 4'd9)      pc = W_valM;
    else                           pc = m_pred;
    model_fetch(pc, st, ic, fn, ra, rb, vc, vp, pr);
    if (rst) begin
      set_bubble();
      m_pred = 64'd0;
    end else begin
      if (!(lu || rp)) m_pred = pr;
      if (!lu) begin
        if (mp || rp) set_bubble();
        else begin
          m_stat = st; m_icode = ic; m_ifun = fn; m_ra = ra; m_rb = rb;
          m_valc = vc; m_valp = vp;
        end
      end
    end
    if (imem_we && imem_addr < 64'(IMEM)) mem_m[imem_addr[9:0]] = imem_wdata;
    exp_q.push_back({m_stat, m_icode, m_ifun, m_ra, m_rb, m_valc, m_valp, m_pred, eb});
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; imem_we = 1'b0; imem_addr = 64'd0; imem_wdata = 8'h00;
    M_icode = 4'h1; W_icode = 4'h1; E_icode = 4'h1; E_dstM = 4'hF;
    d_srcA = 4'hF; d_srcB = 4'hF; e_Cnd = 1'b1; M_Cnd = 1'b1;
    M_valA = 64'd0; W_valM = 64'd0;
  endtask

  task automatic put_byte(input logic [63:0] a, input logic [7:0] b);
    rst = 1'b1; imem_we = 1'b1; imem_addr = a; imem_wdata = b;
    step();
    imem_we = 1'b0;
  endtask

  task automatic put_irmovq(input logic [63:0] a, input logic [3:0] rb, input logic [63:0] v);
    put_byte(a, 8'h30);
    put_byte(a + 64'd1, {4'hF, rb});
    for (int i = 0; i < 8; i++) put_byte(a + 64'(2 + i), v[8*i +: 8]);
  endtask

  task automatic put_jxx(input logic [63:0] a, input logic [63:0] t);
    put_byte(a, 8'h70);
    for (int i = 0; i < 8; i++) put_byte(a + 64'(1 + i), t[8*i +: 8]);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic eb_got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        eb_got = E_bubble;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("E_bubble", 64'(eb_got),   64'(e[0]));
        chk("F_predPC", F_predPC,      e[64:1]);
        chk("D_valP",   D_valP,        e[128:65]);
        chk("D_valC",   D_valC,        e[192:129]);
        chk("D_rB",     64'(D_rB),     64'(e[196:193]));
        chk("D_rA",     64'(D_rA),     64'(e[200:197]));
        chk("D_ifun",   64'(D_ifun),   64'(e[204:201]));
        chk("D_icode",  64'(D_icode),  64'(e[208:205]));
        chk("D_stat",   64'(D_stat),   64'(e[212:209]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned pc, r, len;
    logic [3:0] ic;
    logic [63:0] vc;
    for (int i = 0; i < IMEM; i++) mem_m[i] = 8'h00;
    set_idle();
    rst = 1'b1;
    set_bubble();
    m_pred = 64'd0;
    @(negedge clk);

    for (int i = 0; i < IMEM; i++) put_byte(64'(i), 8'h00);
    chk("rst_predpc", F_predPC, 64'd0);
    chk("rst_icode", 64'(D_icode), 64'h1);
    chk("rst_stat", 64'(D_stat), 64'h8);
    chk("rst_rA", 64'(D_rA), 64'hF);

    // irmovq $5,%rbx then opq at 10
    put_irmovq(64'd0, 4'h3, 64'd5);
    put_byte(64'd10, 8'h60);
    put_byte(64'd11, 8'h12);
    set_idle();
    step();
    chk("irm_icode", 64'(D_icode), 64'h3);
    chk("irm_rA", 64'(D_rA), 64'hF);
    chk("irm_rB", 64'(D_rB), 64'h3);
    chk("irm_valC", D_valC, 64'd5);
    chk("irm_valP", D_valP, 64'd10);
    chk("irm_stat", 64'(D_stat), 64'h8);
    chk("irm_pred", F_predPC, 64'd10);

    // load-use stall
    E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    #1;
    chk("lu_ebubble", 64'(E_bubble), 64'h1);
    step();
    step();
    chk("lu_pred", F_predPC, 64'd10);
    chk("lu_icode", 64'(D_icode), 64'h3);
    chk("lu_valC", D_valC, 64'd5);
    set_idle();
    step();
    chk("lu_rel_icode", 64'(D_icode), 64'h6);
    chk("lu_rel_valP", D_valP, 64'd12);

    // reset during a load-use stall
    E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    step();
    rst = 1'b1;
    step();
    chk("rstlu_pred", F_predPC, 64'd0);
    chk("rstlu_icode", 64'(D_icode), 64'h1);
    set_idle();
    step();
    chk("rstlu_retain", D_valC, 64'd5);

    // jXX to 0x40, mispredict, recover to 9 (halt byte)
    rst = 1'b1;
    put_jxx(64'd0, 64'h40);
    set_idle();
    step();
    chk("jxx_pred", F_predPC, 64'h40);
    chk("jxx_valP", D_valP, 64'd9);
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1;
    chk("mp_ebubble", 64'(E_bubble), 64'h1);
    step();
    chk("mp_bubble", 64'(D_icode), 64'h1);
    set_idle();
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'd9;
    step();
    chk("mp_valP", D_valP, 64'd10);
    chk("hlt_stat", 64'(D_stat), 64'h4);

    // ret at 0x20, return to irmovq at 0x100
    put_jxx(64'd0, 64'h20);
    put_byte(64'h20, 8'h90);
    put_irmovq(64'h100, 4'h6, 64'd7);
    set_idle();
    step();
    step();
    chk("ret_in_d", 64'(D_icode), 64'h9);
    step();
    E_icode = 4'h9;
    step();
    E_icode = 4'h1; M_icode = 4'h9;
    step();
    chk("ret_hold_pred", F_predPC, 64'h21);
    chk("ret_bubble", 64'(D_icode), 64'h1);
    M_icode = 4'h1; W_icode = 4'h9; W_valM = 64'h100;
    step();
    chk("ret_valP", D_valP, 64'h10A);
    chk("ret_valC", D_valC, 64'd7);

    // INS, last-fitting irmovq, ADR at the final byte
    put_byte(64'd0, 8'hC0);
    put_irmovq(64'(IMEM - 10), 4'h4, 64'h1234);
    put_byte(64'(IMEM - 1), 8'h30);
    set_idle();
    step();
    chk("ins_stat", 64'(D_stat), 64'h1);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'(IMEM - 10);
    step();
    chk("edge_stat", 64'(D_stat), 64'h8);
    chk("edge_valC", D_valC, 64'h3000_0000_0000_1234);
    M_valA = 64'(IMEM - 1);
    step();
    chk("adr_stat", 64'(D_stat), 64'h2);
    chk("adr_icode", 64'(D_icode), 64'h1);

    // random program under reset
    for (int i = 0; i < IMEM; i++) prog[i] = 8'h00;
    pc = 0;
    while (pc < IMEM - 12) begin
      r  = $urandom_range(0, 19);
      ic = (r < 16) ? 4'(r) : (r < 18) ? 4'h7 : 4'h9;
      len = len_of(ic);
      prog[pc] = {ic, 4'($urandom_range(0, 15))};
      if (len == 2 || len == 10) prog[pc + 1] = 8'($urandom_range(0, 255));
      if (len >= 9) begin
        if (ic == 4'h7 || ic == 4'h8) vc = 64'($urandom_range(0, IMEM - 12));
        else vc = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) prog[pc + len - 8 + i] = vc[8*i +: 8];
      end
      pc = pc + len;
    end
    for (int i = 0; i < IMEM; i++) put_byte(64'(i), prog[i]);

    // random run
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      rst        = ($urandom_range(0, 99) == 0);
      imem_we    = ($urandom_range(0, 19) == 0);
      imem_addr  = 64'($urandom_range(0, IMEM - 1));
      imem_wdata = 8'($urandom_range(0, 255));
      E_icode    = 4'($urandom_range(0, 11));
      E_dstM     = 4'($urandom_range(0, 15));
      d_srcA     = ($urandom_range(0, 3) == 0) ? E_dstM : 4'($urandom_range(0, 15));
      d_srcB     = 4'($urandom_range(0, 15));
      e_Cnd      = 1'($urandom_range(0, 1));
      r          = $urandom_range(0, 9);
      M_icode    = (r < 2) ? 4'h7 : (r == 2) ? 4'h9 : 4'h1;
      M_Cnd      = 1'($urandom_range(0, 1));
      M_valA     = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFFA
                                                : 64'($urandom_range(0, IMEM - 1));
      W_icode    = ($urandom_range(0, 9) == 0) ? 4'h9 : 4'h1;
      W_valM     = 64'($urandom_range(0, IMEM - 1));
      step();
    end

    set_idle();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d queued, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Fetch stage and pipeline-control unit of the Y86-64 pipelined core. It selects the PC, reads and splits the instruction from a byte-addressed instruction memory, and predicts the next PC. It owns the F and D pipeline registers and generates the stall/bubble controls, including the E_bubble consumed by decode. It is the producer end of the D-register interface that decode reads.

## Interface
- IMEM_BYTES, 1024: instruction memory size in bytes.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- imem_we  in  1  load-port byte write enable.
- imem_addr  in  64  load-port byte address.
- imem_wdata  in  8  load-port byte data.
- M_icode, W_icode  in  4  icodes in M and W.
- M_Cnd  in  1  registered branch condition of the jXX in M.
- M_valA  in  64  fall-through PC of the jXX in M.
- W_valM  in  64  return address of the ret in W.
- E_icode  in  4  icode in E.
- E_dstM  in  4  load destination in E.
- e_Cnd  in  1  branch condition computed in execute.
- d_srcA, d_srcB  in  4  decode source registers.
- D_stat  out  [0:3]  one-hot status.
- D_icode, D_ifun, D_rA, D_rB  out  4  decoded fields.
- D_valC, D_valP  out  64  constant and fall-through PC.
- E_bubble  out  1  inject bubble into E (combinational).
- F_predPC  out  64  predicted PC register.

## Operation
- Status encoding (one-hot [0:3]): AOK=1000, HLT=0100, ADR=0010, INS=0001. RNONE=4'hF.
- Byte 0 holds icode[7:4] and ifun[3:0]. Byte 1 holds rA[7:4] and rB[3:0]. valC is 8 bytes, little-endian.
- Instruction lengths by icode 0..B: 1,1,2,10,10,10,2,9,9,1,2,2.
  - valC starts at pc+2 for icodes 3,4,5 and at pc+1 for 7,8.
  - Absent fields: rA/rB = F, valC = 0.
- f_pc selection, in priority order:
  - M_icode==7 & !M_Cnd: M_valA.
  - W_icode==9: W_valM.
  - Otherwise F_predPC.
- valP = f_pc + length. Predicted PC = valC for icodes 7 and 8, valP otherwise.
- Status:
  - ADR if f_pc + length > IMEM_BYTES, evaluated with full 64-bit compare and no wrap. An ADR fetch forces icode=1, ifun=0.
  - Otherwise INS if icode > B.
  - Otherwise HLT if icode==0.
  - Otherwise AOK.
- Hazard conditions:
  - load_use = E_icode∈{5,B} & E_dstM≠F & E_dstM∈{d_srcA,d_srcB}.
  - ret_pend = 9∈{D_icode,E_icode,M_icode}.
  - mispred = E_icode==7 & !e_Cnd.
- Control outputs:
  - F_stall = load_use | ret_pend.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_pend & !load_use).
  - E_bubble = mispred | load_use.
- D-register update:
  - D_stall holds D.
  - Else D_bubble loads a bubble: stat AOK, icode 1, ifun 0, rA/rB F, valC/valP 0.
  - Else D loads the fetched values.
- F_predPC holds when F_stall; otherwise it loads the predicted PC.
- Imem writes always complete, including during rst.

## Timing
- Imem read is asynchronous. An imem write at edge N is visible to fetch after edge N.
- PC-to-D latency is 1 cycle. D outputs change only on rising clk.
- Reset values: F_predPC=0. D holds a bubble (stat 1000, icode 1, ifun 0, rA=rB=F, valC=valP=0).
- E_bubble is combinational and is 0 while D holds a bubble and E/M are idle.
- rst overrides stall and bubble. Asserting rst mid-stream discards every in-flight fetch at the next edge.
- Simultaneous load_use and ret_pend: D stalls and F stalls. Stall beats bubble.
- Simultaneous mispred and ret_pend: D bubbles. The M-stage mispredict selection wins f_pc over the W-stage ret.
- Fetch does not freeze after HLT/ADR/INS; downstream stages act on stat.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT..POPQ).
  - STAT_AOK/HLT/ADR/INS.
  - RNONE.
  - Instruction-length function.
  - Bubble-value constants, also used by decode's E bubble.
- Sub-module pipe_ctrl holds the purely combinational hazard equations. It outputs F_stall, D_stall, D_bubble, E_bubble.

## Test plan
- Reset, then load 30 F3 05 00 00 00 00 00 00 00 (irmovq $5,%rbx). After 1 clk: D_icode=3, D_rA=F, D_rB=3, D_valC=5, D_valP=10, stat 1000, F_predPC=10.
- jXX at 0 with target 0x40. Next F_predPC=0x40. Drive E_icode=7, e_Cnd=0: E_bubble=1, D becomes a bubble. Next cycle drive M_icode=7, M_Cnd=0, M_valA=9: fetch from 9.
- Load-use: E_icode=5, E_dstM=2, d_srcA=2. F_predPC and all D outputs hold, E_bubble=1. Release: fetch resumes at the held PC.
- ret at 0x20: F stalls and D bubbles for 3 cycles while ret is in D/E/M. With W_icode=9, W_valM=0x100: D_valP reflects the instruction at 0x100.
- Byte 0xC0 gives stat 0001. Fetch at IMEM_BYTES−1 of irmovq gives stat 0010 and icode 1. Byte 0x00 gives stat 0100.
- Assert rst during a load-use stall: next edge F_predPC=0 and D holds the bubble; imem contents are retained.
